// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack port; master = mem_stage, slave = memory
`ifndef ADD_ALU
`define ADD_ALU 4'd0
`endif
`ifndef LW_ALU
`define LW_ALU 4'd10
`endif
`ifndef SW_ALU
`define SW_ALU 4'd11
`endif
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: RV32 MEM stage; EX bundle in, dmem req/ack port (dmem), one-cycle WB pulse out, fault on misalign/timeout
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               valid_ex,
  input  logic [3:0]         alu_op_ex,
  input  logic [31:0]        mem_addr_ex,
  input  logic [31:0]        store_data_ex,
  input  logic [31:0]        rd_data_ex,
  input  logic [4:0]         rd_addr_ex,
  input  logic               rd_we_ex,
  input  logic [31:0]        inst_ex,
  output logic               mem_ready,
  mem_stage_if.master        dmem,
  output logic               wb_valid,
  output logic [4:0]         wb_rd_addr,
  output logic               wb_rd_we,
  output logic [31:0]        wb_rd_data,
  output logic [31:0]        wb_inst,
  output logic               mem_fault
);
  typedef enum logic {IDLE, ACCESS} state_t;
  localparam logic             TO_EN = TIMEOUT != 0;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);
  state_t           state, state_d;
  logic [CNT_W-1:0] wait_cnt, cnt_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d;
  logic             wb_valid_d, wb_we_d, fault_d;
  logic [4:0]       wb_addr_d;
  logic [31:0]      wb_data_d, wb_inst_d;
  logic [4:0]       lat_addr, lat_addr_d;
  logic             lat_we, lat_we_d;
  logic [31:0]      lat_inst, lat_inst_d;
  logic             accept, is_sw, is_mem, misalign, timeout_hit;
  assign mem_ready   = (state == IDLE) && !reset;
  assign accept      = valid_ex && mem_ready;
  assign is_sw       = alu_op_ex == `SW_ALU;
  assign is_mem      = is_sw || alu_op_ex == `LW_ALU;
  assign misalign    = |mem_addr_ex[1:0];
  assign timeout_hit = TO_EN && wait_cnt == LAST;
  assign dmem.req    = state == ACCESS;
  assign dmem.we     = we_q;
  assign dmem.addr   = addr_q;
  assign dmem.wdata  = wdata_q;
  always_comb begin
    state_d    = state;
    cnt_d      = wait_cnt;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    fault_d    = 1'b0;
    wb_addr_d  = wb_rd_addr;
    wb_we_d    = wb_rd_we;
    wb_data_d  = wb_rd_data;
    wb_inst_d  = wb_inst;
    lat_addr_d = lat_addr;
    lat_we_d   = lat_we;
    lat_inst_d = lat_inst;
    if (state == IDLE) begin
      if (accept && is_mem && !misalign) begin
        state_d    = ACCESS;
        cnt_d      = '0;
        we_d       = is_sw;
        addr_d     = mem_addr_ex;
        wdata_d    = is_sw ? store_data_ex : 32'd0;
        lat_addr_d = rd_addr_ex;
        lat_we_d   = rd_we_ex;
        lat_inst_d = inst_ex;
      end else if (accept) begin
        wb_valid_d = 1'b1;
        fault_d    = is_mem;
        wb_addr_d  = rd_addr_ex;
        wb_we_d    = !is_mem && rd_we_ex && rd_addr_ex != 5'd0;
        wb_data_d  = is_mem ? 32'd0 : rd_data_ex;
        wb_inst_d  = inst_ex;
      end
    end else if (dmem.ack || timeout_hit) begin
      state_d    = IDLE;
      wb_valid_d = 1'b1;
      fault_d    = !dmem.ack;
      wb_addr_d  = lat_addr;
      wb_we_d    = dmem.ack && !we_q && lat_we && lat_addr != 5'd0;
      wb_data_d  = dmem.ack && !we_q ? dmem.rdata : 32'd0;
      wb_inst_d  = lat_inst;
    end else begin
      cnt_d = &wait_cnt ? wait_cnt : wait_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wb_valid   <= 1'b0;
      mem_fault  <= 1'b0;
      wb_rd_addr <= '0;
      wb_rd_we   <= 1'b0;
      wb_rd_data <= '0;
      wb_inst    <= '0;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_inst   <= '0;
    end else begin
      state      <= state_d;
      wait_cnt   <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wb_valid   <= wb_valid_d;
      mem_fault  <= fault_d;
      wb_rd_addr <= wb_addr_d;
      wb_rd_we   <= wb_we_d;
      wb_rd_data <= wb_data_d;
      wb_inst    <= wb_inst_d;
      lat_addr   <= lat_addr_d;
      lat_we     <= lat_we_d;
      lat_inst   <= lat_inst_d;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table vectors plus load/store/timeout/reset sequences for mem_stage
`ifndef ADD_ALU
`define ADD_ALU 4'd0
`endif
`ifndef LW_ALU
`define LW_ALU 4'd10
`endif
`ifndef SW_ALU
`define SW_ALU 4'd11
`endif
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_ex = 1'b0;
  logic [3:0]  alu_op_ex = '0;
  logic [31:0] mem_addr_ex = '0, store_data_ex = '0, rd_data_ex = '0, inst_ex = '0;
  logic [4:0]  rd_addr_ex = '0;
  logic        rd_we_ex = 1'b0;
  logic        mem_ready, wb_valid, wb_rd_we, mem_fault;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_data, wb_inst;
  int          n_vec = 0, n_err = 0;
  mem_stage_if dmem ();
  mem_stage #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .valid_ex(valid_ex), .alu_op_ex(alu_op_ex),
    .mem_addr_ex(mem_addr_ex), .store_data_ex(store_data_ex), .rd_data_ex(rd_data_ex),
    .rd_addr_ex(rd_addr_ex), .rd_we_ex(rd_we_ex), .inst_ex(inst_ex), .mem_ready(mem_ready),
    .dmem(dmem), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .wb_rd_we(wb_rd_we),
    .wb_rd_data(wb_rd_data), .wb_inst(wb_inst), .mem_fault(mem_fault)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] inst;
    logic        e_valid;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_inst;
    logic        e_fault;
  } vec_t;
  vec_t vec [7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rd, input logic we, input logic [31:0] inst);
    valid_ex = 1'b1; alu_op_ex = op; mem_addr_ex = addr; store_data_ex = sd;
    rd_addr_ex = rd; rd_we_ex = we; inst_ex = inst; rd_data_ex = 32'h0BAD_0BAD;
    step();
    valid_ex = 1'b0;
  endtask
  initial begin
    vec[0] = '{1'b1, `ADD_ALU, 32'h0,   32'h7,         5'd5,  1'b1, 32'h1111_0001, 1'b1, 1'b1, 5'd5,  32'h7,         32'h1111_0001, 1'b0};
    vec[1] = '{1'b1, `ADD_ALU, 32'h0,   32'h9,         5'd0,  1'b1, 32'h1111_0002, 1'b1, 1'b0, 5'd0,  32'h9,         32'h1111_0002, 1'b0};
    vec[2] = '{1'b0, `ADD_ALU, 32'h0,   32'h55,        5'd6,  1'b1, 32'h1111_0003, 1'b0, 1'b0, 5'd0,  32'h9,         32'h1111_0002, 1'b0};
    vec[3] = '{1'b1, `LW_ALU,  32'h102, 32'h77,        5'd3,  1'b1, 32'h1111_0004, 1'b1, 1'b0, 5'd3,  32'h0,         32'h1111_0004, 1'b1};
    vec[4] = '{1'b1, `SW_ALU,  32'h201, 32'h77,        5'd4,  1'b0, 32'h1111_0005, 1'b1, 1'b0, 5'd4,  32'h0,         32'h1111_0005, 1'b1};
    vec[5] = '{1'b1, `ADD_ALU, 32'h0,   32'hCAFE_BABE, 5'd31, 1'b0, 32'h1111_0006, 1'b1, 1'b0, 5'd31, 32'hCAFE_BABE, 32'h1111_0006, 1'b0};
    vec[6] = '{1'b1, `ADD_ALU, 32'h0,   32'h1234,      5'd31, 1'b1, 32'h1111_0007, 1'b1, 1'b1, 5'd31, 32'h1234,      32'h1111_0007, 1'b0};
    dmem.ack = 1'b0;
    dmem.rdata = '0;
    step();
    step();
    chk("reset mem_ready", {31'd0, mem_ready}, 32'd0);
    chk("reset outputs", {dmem.req, dmem.we, wb_valid, wb_rd_we, mem_fault, wb_rd_addr}, 32'd0);
    chk("reset data", wb_rd_data | wb_inst | dmem.addr | dmem.wdata, 32'd0);
    reset = 1'b0;
    step();
    chk("mem_ready after reset", {31'd0, mem_ready}, 32'd1);
    dmem.ack = 1'b1;
    step();
    chk("idle ack ignored", {30'd0, wb_valid, dmem.req}, 32'd0);
    dmem.ack = 1'b0;
    for (int i = 0; i < 7; i++) begin
      valid_ex = vec[i].valid; alu_op_ex = vec[i].op; mem_addr_ex = vec[i].addr;
      rd_data_ex = vec[i].data; rd_addr_ex = vec[i].rd; rd_we_ex = vec[i].we; inst_ex = vec[i].inst;
      store_data_ex = 32'hFFFF_FFFF;
      step();
      chk($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, {31'd0, vec[i].e_valid});
      chk($sformatf("v%0d wb_rd_we", i), {31'd0, wb_rd_we}, {31'd0, vec[i].e_we});
      chk($sformatf("v%0d wb_rd_addr", i), {27'd0, wb_rd_addr}, {27'd0, vec[i].e_rd});
      chk($sformatf("v%0d wb_rd_data", i), wb_rd_data, vec[i].e_data);
      chk($sformatf("v%0d wb_inst", i), wb_inst, vec[i].e_inst);
      chk($sformatf("v%0d mem_fault", i), {31'd0, mem_fault}, {31'd0, vec[i].e_fault});
      chk($sformatf("v%0d dmem_req/ready", i), {30'd0, dmem.req, mem_ready}, 32'd1);
    end
    valid_ex = 1'b0;
    step();
    chk("pulses clear", {30'd0, wb_valid, mem_fault}, 32'd0);
    issue(`LW_ALU, 32'h100, 32'hAAAA_5555, 5'd7, 1'b1, 32'h2222_0001);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("lw c%0d req/we/ready/valid", i), {28'd0, dmem.req, dmem.we, mem_ready, wb_valid}, 32'h8);
      chk($sformatf("lw c%0d addr", i), dmem.addr, 32'h100);
      chk($sformatf("lw c%0d wdata", i), dmem.wdata, 32'h0);
      if (i == 2) begin
        dmem.ack = 1'b1;
        dmem.rdata = 32'hDEAD_BEEF;
      end
      step();
    end
    dmem.ack = 1'b0;
    chk("lw retire req/ready/valid/we/fault", {27'd0, dmem.req, mem_ready, wb_valid, wb_rd_we, mem_fault}, 32'hE);
    chk("lw retire data", wb_rd_data, 32'hDEAD_BEEF);
    chk("lw retire rd/inst", {wb_inst[26:0], wb_rd_addr}, {27'h222_0001 & 27'h7FF_FFFF, 5'd7});
    step();
    chk("lw pulse", {31'd0, wb_valid}, 32'd0);
    issue(`SW_ALU, 32'h204, 32'h1234_5678, 5'd9, 1'b1, 32'h3333_0001);
    chk("sw req/we", {30'd0, dmem.req, dmem.we}, 32'h3);
    chk("sw addr", dmem.addr, 32'h204);
    chk("sw wdata", dmem.wdata, 32'h1234_5678);
    dmem.ack = 1'b1;
    dmem.rdata = 32'h5A5A_5A5A;
    step();
    dmem.ack = 1'b0;
    chk("sw retire req/valid/we/fault", {28'd0, dmem.req, wb_valid, wb_rd_we, mem_fault}, 32'h4);
    chk("sw retire data", wb_rd_data, 32'h0);
    issue(`LW_ALU, 32'h300, 32'h0, 5'd8, 1'b1, 32'h4444_0001);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to c%0d req/valid", i), {30'd0, dmem.req, wb_valid}, 32'h2);
      step();
    end
    chk("to expire req/valid/we/fault", {28'd0, dmem.req, wb_valid, wb_rd_we, mem_fault}, 32'h5);
    chk("to expire data", wb_rd_data, 32'h0);
    step();
    chk("to fault pulse", {30'd0, wb_valid, mem_fault}, 32'd0);
    issue(`LW_ALU, 32'h304, 32'h0, 5'd10, 1'b1, 32'h4444_0002);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ack4 c%0d req", i), {31'd0, dmem.req}, 32'd1);
      if (i == 3) begin
        dmem.ack = 1'b1;
        dmem.rdata = 32'hFEED_F00D;
      end
      step();
    end
    dmem.ack = 1'b0;
    chk("ack4 req/valid/we/fault", {28'd0, dmem.req, wb_valid, wb_rd_we, mem_fault}, 32'h6);
    chk("ack4 data", wb_rd_data, 32'hFEED_F00D);
    issue(`LW_ALU, 32'h400, 32'h0, 5'd11, 1'b1, 32'h5555_0001);
    chk("rst c1 req", {31'd0, dmem.req}, 32'd1);
    step();
    chk("rst c2 req", {31'd0, dmem.req}, 32'd1);
    reset = 1'b1;
    step();
    chk("rst mid req/ready/valid/fault/we", {27'd0, dmem.req, mem_ready, wb_valid, mem_fault, wb_rd_we}, 32'd0);
    chk("rst mid data", wb_rd_data | wb_inst | dmem.addr, 32'd0);
    reset = 1'b0;
    dmem.ack = 1'b1;
    dmem.rdata = 32'h9999_9999;
    step();
    dmem.ack = 1'b0;
    chk("late ack req/ready/valid", {29'd0, dmem.req, mem_ready, wb_valid}, 32'h2);
    chk("late ack data", wb_rd_data, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
